// File: rtl/tx_stream_mux_pkg.sv
//==============================================================================
// tx_stream_pkg - shared FSM state type and channel-index width helper (rev 1.0)
//==============================================================================
`default_nettype none

package tx_stream_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    LOAD = 3'd2,
    HDR  = 3'd3,
    SEND = 3'd4
  } state_e;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/tx_stream_mux_if.sv
//==============================================================================
// tx_stream_mux_if - byte stream handshake towards uart_tx (rev 1.0)
//==============================================================================
`default_nettype none

interface tx_stream_mux_if #(
  parameter int WIDTH = 8,
  parameter int CH_W  = 2
);

  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [CH_W-1:0]  tx_ch;

  modport master (output tx_data, output tx_valid, output tx_ch, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input tx_ch, output tx_ready);

endinterface

`default_nettype wire

// File: rtl/tx_stream_mux_chan_fifo.sv
//==============================================================================
// chan_fifo - single-clock FIFO with registered read and sticky overflow (rev 1.0)
//==============================================================================
`default_nettype none

module chan_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  input  wire logic                  flush,
  input  wire logic                  wr_en,
  input  wire logic [WIDTH-1:0]      wr_data,
  input  wire logic                  rd_en,
  output logic      [WIDTH-1:0]      rd_data,
  output logic                       empty,
  output logic                       full,
  output logic      [ADDR_WIDTH:0]   count,
  output logic                       overflow
);

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic [WIDTH-1:0]      rd_data_q;
  logic                  overflow_q;
  logic                  rd_ok;
  logic                  wr_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign count    = count_q;
  assign rd_data  = rd_data_q;
  assign overflow = overflow_q;

  // A read frees a slot in the same cycle, so a write while full still lands.
  assign rd_ok = rd_en & ~empty & ~flush;
  assign wr_ok = wr_en & (~full | rd_ok) & ~flush;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rd_data_q  <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (rd_ok) begin
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        rd_data_q <= mem_q[rd_ptr_q];
      end
      if (wr_ok && !rd_ok) begin
        count_q <= count_q + 1'b1;
      end else if (rd_ok && !wr_ok) begin
        count_q <= count_q - 1'b1;
      end
      if (wr_en && !wr_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tx_stream_mux.sv
//==============================================================================
// tx_stream_mux - NUM_CH sample FIFOs drained into one byte stream (rev 1.0)
//==============================================================================
`default_nettype none

module tx_stream_mux
  import tx_stream_pkg::*;
#(
  parameter  int               NUM_CH     = 4,
  parameter  int               WIDTH      = 8,
  parameter  int               DEPTH      = 512,
  parameter  int               ADDR_WIDTH = 9,
  parameter  logic [WIDTH-1:0] TAG_BASE   = 8'hA0,
  localparam int               CH_W       = ch_w(NUM_CH)
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic [NUM_CH-1:0]        wr_en,
  input  wire logic [NUM_CH*WIDTH-1:0]  wr_data,
  input  wire logic [CH_W-1:0]          sel,
  input  wire logic                     rr_mode,
  input  wire logic                     tx_en,
  input  wire logic                     flush,
  tx_stream_mux_if.master               tx,
  output logic      [NUM_CH-1:0]        empty,
  output logic      [NUM_CH-1:0]        full,
  output logic      [NUM_CH-1:0]        overflow,
  output logic      [ADDR_WIDTH:0]      occ_sel
);

  logic [NUM_CH-1:0]   rd_en;
  logic [WIDTH-1:0]    rd_data [NUM_CH];
  logic [ADDR_WIDTH:0] count   [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_fifo
    chan_fifo #(
      .WIDTH      (WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .wr_en    (wr_en[c]),
      .wr_data  (wr_data[c*WIDTH +: WIDTH]),
      .rd_en    (rd_en[c]),
      .rd_data  (rd_data[c]),
      .empty    (empty[c]),
      .full     (full[c]),
      .count    (count[c]),
      .overflow (overflow[c])
    );
  end

  state_e           state_q, state_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic             mode_q, mode_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0] sample_q, sample_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic [CH_W-1:0]  tx_ch_q, tx_ch_d;

  logic             sel_empty;
  logic             rr_found;
  logic [CH_W-1:0]  rr_ch;
  logic [CH_W:0]    rr_idx;
  logic             xfer;

  // sel is decoded by comparison so widths that exceed NUM_CH read as empty.
  always_comb begin
    sel_empty = 1'b1;
    occ_sel   = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (sel == CH_W'(c)) begin
        sel_empty = empty[c];
        occ_sel   = count[c];
      end
    end
  end

  always_comb begin
    rr_found = 1'b0;
    rr_ch    = '0;
    rr_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      rr_idx = {1'b0, rr_ptr_q} + (CH_W+1)'(i);
      if (rr_idx >= (CH_W+1)'(NUM_CH)) begin
        rr_idx = rr_idx - (CH_W+1)'(NUM_CH);
      end
      if (!rr_found && !empty[rr_idx[CH_W-1:0]]) begin
        rr_found = 1'b1;
        rr_ch    = rr_idx[CH_W-1:0];
      end
    end
  end

  assign xfer = tx_valid_q & tx.tx_ready;

  always_comb begin
    state_d    = state_q;
    ch_d       = ch_q;
    mode_d     = mode_q;
    rr_ptr_d   = rr_ptr_q;
    sample_d   = sample_q;
    tx_data_d  = tx_data_q;
    tx_valid_d = tx_valid_q;
    tx_ch_d    = tx_ch_q;
    rd_en      = '0;

    unique case (state_q)
      IDLE: begin
        if (tx_en) begin
          if (!rr_mode && !sel_empty) begin
            ch_d    = sel;
            mode_d  = 1'b0;
            state_d = RD;
          end else if (rr_mode && rr_found) begin
            ch_d    = rr_ch;
            mode_d  = 1'b1;
            state_d = RD;
          end
        end
      end
      RD: begin
        rd_en[ch_q] = 1'b1;
        state_d     = LOAD;
      end
      LOAD: begin
        sample_d   = rd_data[ch_q];
        tx_valid_d = 1'b1;
        tx_ch_d    = ch_q;
        if (mode_q) begin
          tx_data_d = TAG_BASE | WIDTH'(ch_q);
          state_d   = HDR;
        end else begin
          tx_data_d = rd_data[ch_q];
          state_d   = SEND;
        end
      end
      HDR: begin
        if (xfer) begin
          tx_data_d = sample_q;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          tx_valid_d = 1'b0;
          rr_ptr_d   = (ch_q == CH_W'(NUM_CH-1)) ? '0 : ch_q + 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d    = IDLE;
      tx_valid_d = 1'b0;
      rd_en      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ch_q       <= '0;
      mode_q     <= 1'b0;
      rr_ptr_q   <= '0;
      sample_q   <= '0;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      tx_ch_q    <= '0;
    end else begin
      state_q    <= state_d;
      ch_q       <= ch_d;
      mode_q     <= mode_d;
      rr_ptr_q   <= rr_ptr_d;
      sample_q   <= sample_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      tx_ch_q    <= tx_ch_d;
    end
  end

  assign tx.tx_data  = tx_data_q;
  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_ch    = tx_ch_q;

endmodule

`default_nettype wire

// File: tb/tb_tx_stream_mux.sv
//==============================================================================
// tb_tx_stream_mux - scoreboard bench for tx_stream_mux (rev 1.0)
//==============================================================================
`default_nettype none

module tb_tx_stream_mux;

  localparam int NUM_CH = 4;
  localparam int WIDTH  = 8;
  localparam int DEPTH  = 512;
  localparam logic [7:0] TAG = 8'hA0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  wr_en = '0;
  logic [31:0] wr_data = '0;
  logic [1:0]  sel = '0;
  logic        rr_mode = 1'b0;
  logic        tx_en = 1'b0;
  logic        flush = 1'b0;
  logic [3:0]  empty, full, overflow;
  logic [9:0]  occ_sel;

  tx_stream_mux_if #(.WIDTH(WIDTH), .CH_W(2)) txif ();

  tx_stream_mux dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .sel      (sel),
    .rr_mode  (rr_mode),
    .tx_en    (tx_en),
    .flush    (flush),
    .tx       (txif),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .occ_sel  (occ_sel)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: per-channel FIFO contents, overflow flags, round-robin pointer.
  logic [7:0] mmem [NUM_CH][DEPTH];
  int         mhead [NUM_CH];
  int         mcnt  [NUM_CH];
  bit         movf  [NUM_CH];
  int         mrr = 0;

  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t sb[$];

  task automatic model_wr(input int c, input logic [7:0] d);
    if (mcnt[c] < DEPTH) begin
      mmem[c][(mhead[c] + mcnt[c]) % DEPTH] = d;
      mcnt[c]++;
    end else begin
      movf[c] = 1'b1;
    end
  endtask

  task automatic model_pop(input int c, output logic [7:0] d);
    d = mmem[c][mhead[c]];
    mhead[c] = (mhead[c] + 1) % DEPTH;
    mcnt[c]--;
  endtask

  task automatic model_clear();
    for (int c = 0; c < NUM_CH; c++) begin
      mhead[c] = 0;
      mcnt[c]  = 0;
      movf[c]  = 1'b0;
    end
    sb.delete();
  endtask

  // Expected byte order for draining everything currently queued in one mode.
  task automatic plan_drain(input bit rr, input int s);
    logic [7:0] d;
    int found;
    if (!rr) begin
      while (mcnt[s] > 0) begin
        model_pop(s, d);
        sb.push_back('{d, s});
        mrr = (s + 1) % NUM_CH;
      end
    end else begin
      forever begin
        found = -1;
        for (int i = 0; i < NUM_CH; i++) begin
          if (found < 0 && mcnt[(mrr + i) % NUM_CH] > 0) found = (mrr + i) % NUM_CH;
        end
        if (found < 0) break;
        model_pop(found, d);
        sb.push_back('{TAG | 8'(found), found});
        sb.push_back('{d, found});
        mrr = (found + 1) % NUM_CH;
      end
    end
  endtask

  function automatic logic [3:0] m_empty();
    for (int c = 0; c < NUM_CH; c++) m_empty[c] = (mcnt[c] == 0);
  endfunction

  function automatic logic [3:0] m_full();
    for (int c = 0; c < NUM_CH; c++) m_full[c] = (mcnt[c] == DEPTH);
  endfunction

  function automatic logic [3:0] m_ovf();
    for (int c = 0; c < NUM_CH; c++) m_ovf[c] = movf[c];
  endfunction

  // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
  bit         mon_en = 1'b0;
  bit         pv = 1'b0;
  bit         pr = 1'b0;
  logic [7:0] pd = '0;
  logic [1:0] pc = '0;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (pv && !pr) begin
        check("hold_valid", 32'(txif.tx_valid), 32'd1);
        check("hold_data", {22'd0, txif.tx_ch, txif.tx_data}, {22'd0, pc, pd});
      end
      if (txif.tx_valid && txif.tx_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_byte: got %0h ch %0d, expected no transfer",
                   txif.tx_data, txif.tx_ch);
        end else begin
          e = sb.pop_front();
          check("tx_data", 32'(txif.tx_data), 32'(e.d));
          check("tx_ch", 32'(txif.tx_ch), 32'(e.c));
        end
      end
    end
    pv = txif.tx_valid;
    pr = txif.tx_ready;
    pd = txif.tx_data;
    pc = txif.tx_ch;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input int c, input logic [7:0] d);
    wr_en = '0;
    wr_en[c] = 1'b1;
    wr_data[c*8 +: 8] = d;
    tick();
    wr_en = '0;
  endtask

  task automatic wr(input int c, input logic [7:0] d);
    model_wr(c, d);
    drive_wr(c, d);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!txif.tx_valid && n < 20) begin
      tick();
      n++;
    end
    check({"wait_valid_", name}, 32'(txif.tx_valid), 32'd1);
  endtask

  task automatic wait_drain(input string name, input bit rand_ready, input int budget);
    int n = 0;
    while ((sb.size() != 0 || txif.tx_valid) && n < budget) begin
      txif.tx_ready = rand_ready ? (($urandom % 4) != 0) : 1'b1;
      tick();
      n++;
    end
    txif.tx_ready = 1'b1;
    repeat (8) tick();
    check({"drain_left_", name}, 32'(sb.size()), 32'd0);
    check({"drain_idle_", name}, 32'(txif.tx_valid), 32'd0);
  endtask

  task automatic check_flags(input string name);
    check({"empty_", name}, 32'(empty), 32'(m_empty()));
    check({"full_", name}, 32'(full), 32'(m_full()));
    check({"ovf_", name}, 32'(overflow), 32'(m_ovf()));
    check({"occ_", name}, 32'(occ_sel), 32'(mcnt[sel]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] d;
    logic [3:0] mask;
    bit rr;

    txif.tx_ready = 1'b0;
    model_clear();

    // Reset state
    tick();
    tick();
    check("rst_valid", 32'(txif.tx_valid), 32'd0);
    check("rst_data", 32'(txif.tx_data), 32'd0);
    check("rst_ch", 32'(txif.tx_ch), 32'd0);
    check("rst_empty", 32'(empty), 32'hF);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_occ", 32'(occ_sel), 32'd0);
    #3 rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Single mode, writes arriving while draining
    sel = 2'd1;
    rr_mode = 1'b0;
    txif.tx_ready = 1'b1;
    tx_en = 1'b1;
    model_wr(1, 8'h11);
    model_wr(1, 8'h22);
    model_wr(1, 8'h33);
    plan_drain(0, 1);
    drive_wr(1, 8'h11);
    n = 0;
    while (!txif.tx_valid && n < 10) begin
      if (n == 0) drive_wr(1, 8'h22);
      else if (n == 1) drive_wr(1, 8'h33);
      else tick();
      n++;
    end
    check("first_valid_latency_ok", 32'(n <= 4), 32'd1);
    wait_drain("single", 1'b0, 200);
    check("single_empty1", 32'(empty[1]), 32'd1);

    // Backpressure: 20 stalled cycles, then exactly one transfer
    tx_en = 1'b0;
    txif.tx_ready = 1'b0;
    wr(1, 8'h5A);
    plan_drain(0, 1);
    tx_en = 1'b1;
    wait_valid("bp");
    repeat (20) tick();
    check("bp_data", 32'(txif.tx_data), 32'h5A);
    wait_drain("bp", 1'b0, 50);

    // Randomized phases
    for (int k = 0; k < 8; k++) begin
      tx_en = 1'b0;
      repeat ($urandom_range(1, 30)) begin
        mask = 4'($urandom);
        wr_en = '0;
        for (int c = 0; c < NUM_CH; c++) begin
          if (mask[c]) begin
            d = 8'($urandom);
            model_wr(c, d);
            wr_en[c] = 1'b1;
            wr_data[c*8 +: 8] = d;
          end
        end
        tick();
        wr_en = '0;
      end
      rr = 1'($urandom);
      rr_mode = rr;
      sel = 2'($urandom);
      tick();
      check_flags("rand");
      plan_drain(rr, int'(sel));
      tx_en = 1'b1;
      wait_drain("rand", 1'b1, 3000);
      if (!rr) begin
        rr_mode = 1'b1;
        plan_drain(1'b1, 0);
        wait_drain("rand_rest", 1'b1, 3000);
      end
    end

    // sel change while a byte is held
    tx_en = 1'b0;
    rr_mode = 1'b0;
    sel = 2'd1;
    wr(1, 8'h31);
    wr(1, 8'h32);
    wr(2, 8'h41);
    wr(2, 8'h42);
    wr(2, 8'h43);
    model_pop(1, d);
    sb.push_back('{d, 1});
    mrr = 2;
    plan_drain(0, 2);
    plan_drain(0, 1);
    txif.tx_ready = 1'b0;
    tx_en = 1'b1;
    wait_valid("midsel");
    sel = 2'd2;
    tick();
    txif.tx_ready = 1'b1;
    n = 0;
    while (sb.size() > 1 && n < 100) begin
      tick();
      n++;
    end
    repeat (6) tick();
    check("midsel_remaining", 32'(sb.size()), 32'd1);
    sel = 2'd1;
    wait_drain("midsel", 1'b0, 100);

    // Overflow on channel 3
    tx_en = 1'b0;
    sel = 2'd3;
    for (int i = 0; i < DEPTH + 1; i++) wr(3, 8'(i + 7));
    check_flags("ovf");
    check("ovf_occ512", 32'(occ_sel), 32'd512);
    plan_drain(0, 3);
    tx_en = 1'b1;
    wait_drain("ovf", 1'b0, 4000);
    check("ovf_sticky", 32'(overflow[3]), 32'd1);

    // Flush mid-stream
    tx_en = 1'b0;
    sel = 2'd0;
    wr(0, 8'hC1);
    wr(0, 8'hC2);
    wr(2, 8'hC3);
    txif.tx_ready = 1'b0;
    tx_en = 1'b1;
    wait_valid("flush");
    mon_en = 1'b0;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_valid", 32'(txif.tx_valid), 32'd0);
    check("flush_empty", 32'(empty), 32'hF);
    check("flush_ovf", 32'(overflow), 32'd0);
    model_clear();
    txif.tx_ready = 1'b1;
    tick();
    mon_en = 1'b1;
    repeat (10) tick();

    // Async reset while tx_valid is high
    tx_en = 1'b0;
    sel = 2'd2;
    wr(2, 8'hD0);
    txif.tx_ready = 1'b0;
    tx_en = 1'b1;
    wait_valid("arst");
    mon_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(txif.tx_valid), 32'd0);
    check("arst_empty", 32'(empty), 32'hF);
    check("arst_data", 32'(txif.tx_data), 32'd0);
    model_clear();
    mrr = 0;
    tx_en = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    mon_en = 1'b1;

    // Round-robin with tags: channels 0 and 2 only
    rr_mode = 1'b1;
    txif.tx_ready = 1'b1;
    wr(0, 8'h05);
    wr(2, 8'h07);
    plan_drain(1, 0);
    check("rr_plan_len", 32'(sb.size()), 32'd4);
    tx_en = 1'b1;
    wait_drain("rr", 1'b0, 100);

    tx_en = 1'b0;
    mon_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
